adder_tree_sum_accumulator: RTL and testbench

//  Downstream consumer of the adder tree's registered sum output.
//  - Accumulates ACC_COUNT consecutive tree sums into one wide result.
//  - Presents the result on a valid/ready output; the stage after it may stall.
//  - Lets the tree run every cycle while downstream sees one block-sum per ACC_COUNT samples.

---
 rtl/adder_tree_pkg.sv | 16 +
 rtl/adder_tree_sum_accumulator_acc_ctrl.sv | 64 ++++++
 rtl/adder_tree_sum_accumulator.sv | 94 +++++++++
 tb/tb_adder_tree_sum_accumulator.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants, state type and width helper for the adder-tree accumulator.
package adder_tree_pkg;

    localparam int unsigned ADDER_WIDTH_DEF = 9;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    function automatic int unsigned acc_width(input int unsigned adder_w,
                                              input int unsigned count);
        return adder_w + 1 + $clog2(count);
    endfunction

endpackage

// File: rtl/adder_tree_sum_accumulator_acc_ctrl.sv
// Block control: ACCUM/HOLD state, sample counter, handshake and result-valid flag.
module adder_tree_acc_ctrl
    import adder_tree_pkg::*;
#(
    parameter int unsigned ACC_COUNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic in_valid_i,
    input  logic out_ready_i,
    output logic in_ready_o,
    output logic accept_o,
    output logic last_o,
    output logic out_valid_o
);

    localparam int unsigned CNT_W = $clog2(ACC_COUNT);

    acc_state_t         state_q;
    logic [CNT_W-1:0]   count_q;
    logic               out_valid_q;

    // Ready in HOLD only when the held result leaves this same cycle.
    assign in_ready_o  = (state_q == ACCUM) | ((state_q == HOLD) & out_ready_i);
    assign accept_o    = in_valid_i & in_ready_o;
    assign last_o      = accept_o & (state_q == ACCUM) & (count_q == CNT_W'(ACC_COUNT - 1));
    assign out_valid_o = out_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (clear_i) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (last_o) begin
                        count_q     <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (accept_o) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                        count_q     <= accept_o ? CNT_W'(1) : '0;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: rtl/adder_tree_sum_accumulator.sv
// Accumulates ACC_COUNT tree sums into one result on a valid/ready output.
// Define ACC_SATURATE_EN for clamping accumulation with a sticky overflow flag.
module adder_tree_sum_accumulator
    import adder_tree_pkg::*;
#(
    parameter int unsigned ADDER_WIDTH = ADDER_WIDTH_DEF,
    parameter int unsigned ACC_COUNT   = 16,
    parameter int unsigned ACC_WIDTH   = acc_width(ADDER_WIDTH, ACC_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [ADDER_WIDTH:0]   in_sum,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow
);

    logic                 accept;
    logic                 last;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
    logic [ACC_WIDTH-1:0] acc_next;

    adder_tree_acc_ctrl #(
        .ACC_COUNT (ACC_COUNT)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .out_ready_i (out_ready),
        .in_ready_o  (in_ready),
        .accept_o    (accept),
        .last_o      (last),
        .out_valid_o (out_valid)
    );

`ifdef ACC_SATURATE_EN
    localparam int unsigned SAMPLE_W = ADDER_WIDTH + 1;
    localparam int unsigned SUM_W    = ((ACC_WIDTH > SAMPLE_W) ? ACC_WIDTH : SAMPLE_W) + 1;

    logic [SUM_W-1:0] sum_w;
    logic             carry;
    logic             overflow_q;

    // Acc is zero at a block start, so a clamped acc stays all-ones until the block ends.
    assign sum_w    = SUM_W'(acc_q) + SUM_W'(in_sum);
    assign carry    = |sum_w[SUM_W-1:ACC_WIDTH];
    assign acc_next = carry ? '1 : sum_w[ACC_WIDTH-1:0];
    assign overflow = overflow_q;

    // Sticky until rst; clear deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (!clear && accept && carry) begin
            overflow_q <= 1'b1;
        end
    end
`else
    assign acc_next = acc_q + ACC_WIDTH'(in_sum);
    assign overflow = 1'b0;
`endif

    always_comb begin
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        if (clear) begin
            acc_d = '0;
        end else if (last) begin
            acc_d     = '0;
            acc_out_d = acc_next;
        end else if (accept) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            acc_out_q <= '0;
        end else begin
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
        end
    end

    assign acc_out = acc_out_q;

endmodule

// File: tb/tb_adder_tree_sum_accumulator.sv
// Directed bench: ACC_COUNT=4 instance for handshake/gap/clear/reset cases,
// ACC_COUNT=2 / ACC_WIDTH=10 instance for the wrap/saturation boundary.
module tb_adder_tree_sum_accumulator;

    localparam int unsigned AW = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;

    logic [AW:0] a_in_sum;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [11:0] a_acc_out;
    logic        a_out_valid;
    logic        a_out_ready;
    logic        a_overflow;

    logic [AW:0] b_in_sum;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [9:0]  b_acc_out;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_tree_sum_accumulator #(
        .ADDER_WIDTH (AW),
        .ACC_COUNT   (4)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_sum    (a_in_sum),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .acc_out   (a_acc_out),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .overflow  (a_overflow)
    );

    adder_tree_sum_accumulator #(
        .ADDER_WIDTH (AW),
        .ACC_COUNT   (2),
        .ACC_WIDTH   (10)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_sum    (b_in_sum),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .acc_out   (b_acc_out),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .overflow  (b_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [AW:0] v, input logic valid);
        a_in_sum   = v;
        a_in_valid = valid;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        clear       = 1'b0;
        a_in_sum    = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        b_in_sum    = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        tick();
        tick();

        check("rst_acc_out",   32'(a_acc_out),   32'd0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_overflow",  32'(b_overflow),  32'd0);
        check("rst_in_ready",  32'(a_in_ready),  32'd1);
        rst = 1'b0;
        tick();

        // 1: back-to-back 1,2,3,4
        drive_a(10'd1, 1'b1);
        drive_a(10'd2, 1'b1);
        drive_a(10'd3, 1'b1);
        check("t1_not_yet", 32'(a_out_valid), 32'd0);
        drive_a(10'd4, 1'b1);
        check("t1_valid", 32'(a_out_valid), 32'd1);
        check("t1_sum",   32'(a_acc_out),   32'd10);
        drive_a(10'd0, 1'b0);
        check("t1_one_cycle", 32'(a_out_valid), 32'd0);

        // 2: stall with a pending sample, then handoff on the same cycle
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_a(10'd1, 1'b1);
        check("t2_valid", 32'(a_out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            a_in_sum   = 10'd9;
            a_in_valid = 1'b1;
            check("t2_stall_ready", 32'(a_in_ready), 32'd0);
            tick();
            check("t2_stall_sum",   32'(a_acc_out),   32'd4);
            check("t2_stall_valid", 32'(a_out_valid), 32'd1);
        end
        a_out_ready = 1'b1;
        a_in_sum    = 10'd7;
        #1;
        check("t2_handoff_ready", 32'(a_in_ready), 32'd1);
        tick();
        check("t2_handoff_drop", 32'(a_out_valid), 32'd0);
        drive_a(10'd1, 1'b1);
        drive_a(10'd1, 1'b1);
        drive_a(10'd1, 1'b1);
        check("t2_next_valid", 32'(a_out_valid), 32'd1);
        check("t2_next_sum",   32'(a_acc_out),   32'd10);
        drive_a(10'd0, 1'b0);

        // 3: gaps do not end a block
        drive_a(10'd5, 1'b1);
        drive_a(10'd0, 1'b0);
        drive_a(10'd5, 1'b1);
        drive_a(10'd0, 1'b0);
        drive_a(10'd0, 1'b0);
        drive_a(10'd5, 1'b1);
        check("t3_not_yet", 32'(a_out_valid), 32'd0);
        drive_a(10'd5, 1'b1);
        check("t3_valid", 32'(a_out_valid), 32'd1);
        check("t3_sum",   32'(a_acc_out),   32'd20);
        drive_a(10'd0, 1'b0);

        // 4: clear on the 3rd sample discards the block and that sample
        drive_a(10'd1, 1'b1);
        drive_a(10'd1, 1'b1);
        clear = 1'b1;
        drive_a(10'd1, 1'b1);
        clear = 1'b0;
        check("t4_cleared", 32'(a_out_valid), 32'd0);
        drive_a(10'd1, 1'b1);
        drive_a(10'd1, 1'b1);
        drive_a(10'd1, 1'b1);
        check("t4_not_yet", 32'(a_out_valid), 32'd0);
        drive_a(10'd1, 1'b1);
        check("t4_valid", 32'(a_out_valid), 32'd1);
        check("t4_sum",   32'(a_acc_out),   32'd4);
        drive_a(10'd0, 1'b0);

        // 5: 1023 + 1023 into a 10-bit accumulator
        b_in_sum   = 10'd1023;
        b_in_valid = 1'b1;
        tick();
        tick();
        b_in_valid = 1'b0;
        check("t5_valid", 32'(b_out_valid), 32'd1);
`ifdef ACC_SATURATE_EN
        check("t5_sum",      32'(b_acc_out),  32'd1023);
        check("t5_overflow", 32'(b_overflow), 32'd1);
`else
        check("t5_sum",      32'(b_acc_out),  32'd1022);
        check("t5_overflow", 32'(b_overflow), 32'd0);
`endif
        tick();
        check("t5_drain", 32'(b_out_valid), 32'd0);

        // 6: async reset while holding a result
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_a(10'd3, 1'b1);
        a_in_valid = 1'b0;
        check("t6_hold_sum", 32'(a_acc_out), 32'd12);
        rst = 1'b1;
        #1;
        check("t6_rst_valid",    32'(a_out_valid), 32'd0);
        check("t6_rst_sum",      32'(a_acc_out),   32'd0);
        check("t6_rst_overflow", 32'(b_overflow),  32'd0);
        #1;
        rst         = 1'b0;
        a_out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) drive_a(10'd2, 1'b1);
        check("t6_valid", 32'(a_out_valid), 32'd1);
        check("t6_sum",   32'(a_acc_out),   32'd8);
        drive_a(10'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
